// File: rtl/qpll_reset_seq.sv
// qpll_reset_seq: power-up / reset sequencer for a GTXE2_COMMON QPLL.
// Waits for the fabric PLL to lock, holds the QPLL in power-down, pulses its
// reset, waits for lock with a timeout and bounded retries, then qualifies
// lock stability before raising qpll_ready.
module qpll_reset_seq #(
    parameter int unsigned PD_CYCLES     = 500,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 100000,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       qpll_lock,
    input  logic       qpll_refclklost,
    input  logic       restart,
    output logic       qpllpd,
    output logic       qpllreset,
    output logic       qpll_ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int unsigned MaxAB  = (PD_CYCLES > RESET_CYCLES) ? PD_CYCLES : RESET_CYCLES;
    localparam int unsigned MaxCD  = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned MaxAll = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned CntW   = ($clog2(MaxAll + 1) > 17) ? $clog2(MaxAll + 1) : 17;

    typedef enum logic [2:0] {
        StWaitPll,
        StPowerdown,
        StReset,
        StWaitLock,
        StSettle,
        StReady,
        StFault
    } state_e;

    // Bit 0: pll_locked, bit 1: qpll_lock, bit 2: qpll_refclklost.
    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic       pll_s, lock_s, lost_s;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        retry_q, retry_d;
    logic              pd_q, pd_d;
    logic              rstq_q, rstq_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;

    assign pll_s  = sync_q[0];
    assign lock_s = sync_q[1];
    assign lost_s = sync_q[2];

    // Counter preload for a state; dwell of N cycles means N-1 down to 0.
    function automatic logic [CntW-1:0] load_val(input state_e s);
        logic [CntW-1:0] v;
        v = '0;
        unique case (s)
            StPowerdown: v = CntW'(PD_CYCLES - 1);
            StReset:     v = CntW'(RESET_CYCLES - 1);
            StWaitLock:  v = CntW'(LOCK_TIMEOUT - 1);
            StSettle:    v = CntW'(SETTLE_CYCLES - 1);
            default:     v = '0;
        endcase
        return v;
    endfunction

    // Two-flop synchronizer stages for the asynchronous status inputs.
    always_comb begin
        meta_d = {qpll_refclklost, qpll_lock, pll_locked};
        sync_d = meta_q;
    end

    // Next state, dwell counter, retry bookkeeping and registered outputs.
    always_comb begin
        logic fail;
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
        fail    = 1'b0;

        unique case (state_q)
            StWaitPll: begin
                if (pll_s) state_d = StPowerdown;
            end
            StPowerdown: begin
                if (cnt_q == '0) state_d = StReset;
            end
            StReset: begin
                if (cnt_q == '0) state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock takes precedence over a simultaneous timeout.
                if (lock_s && !lost_s) state_d = StSettle;
                else if (cnt_q == '0)  fail = 1'b1;
            end
            StSettle: begin
                if (!lock_s || lost_s) fail = 1'b1;
                else if (cnt_q == '0)  state_d = StReady;
            end
            StReady: begin
                // A loss after ready is a fresh event, not a retry.
                if (!lock_s || lost_s) begin
                    state_d = StReset;
                    retry_d = 4'd0;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: state_d = StWaitPll;
        endcase

        if (fail) begin
            if (retry_q >= 4'(MAX_RETRIES)) begin
                state_d = StFault;
            end else begin
                state_d = StReset;
                retry_d = retry_q + 4'd1;
            end
        end

        if (restart) begin
            state_d = StWaitPll;
            retry_d = 4'd0;
        end else if (!pll_s && state_q != StWaitPll && state_q != StFault) begin
            state_d = StWaitPll;
        end

        if (state_d != state_q) cnt_d = load_val(state_d);

        // Outputs decoded from the next state so they change with the state register.
        pd_d    = (state_d == StWaitPll) || (state_d == StPowerdown) || (state_d == StFault);
        rstq_d  = pd_d || (state_d == StReset);
        ready_d = (state_d == StReady);
        fault_d = (state_d == StFault);
    end

    // Synchronizer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    // Sequencer state, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitPll;
            cnt_q   <= '0;
            retry_q <= 4'd0;
            pd_q    <= 1'b1;
            rstq_q  <= 1'b1;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            pd_q    <= pd_d;
            rstq_q  <= rstq_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    assign qpllpd      = pd_q;
    assign qpllreset   = rstq_q;
    assign qpll_ready  = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule
